deskew_unloader: RTL
====================

DESKEW_UNLOADER -- requirements
Module: deskew_unloader

Interface
REQ-001 Parameter DIM, default 8, lane count (number of skewed streams); SHALL be >= 2.
REQ-002 Parameter BITS, default 64, bits per lane element.
REQ-003 Parameter OUT_DEPTH, default 4, output row buffer entries; SHALL be >= 2.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  shift strobe; lane pipelines advance only on edges where en=1.
REQ-007 clr  in  1  synchronous clear of all datapath state.
REQ-008 lane_in  in  DIM*BITS  skewed lane data; lane i at [i*BITS +: BITS].
REQ-009 in_valid  in  1  marks lane-0 element of a new row on the current strobe.
REQ-010 out_data  out  DIM*BITS  aligned row at buffer head; lane i at [i*BITS +: BITS].
REQ-011 out_valid  out  1  buffer non-empty.
REQ-012 out_ready  in  1  consumer accepts head row when out_valid=1.
REQ-013 almost_full  out  1  buffer count >= OUT_DEPTH-1.
REQ-014 overflow  out  1  sticky: a completed row was discarded.
REQ-015 rows_out  out  32  count of accepted output handshakes.

Function
REQ-016 Input skew model: row r lane i element arrives on strobe k+i, where strobe k carries in_valid=1 for row r.
REQ-017 Lane i SHALL be delayed by DIM-1-i strobes; lane DIM-1 has zero delay.
REQ-018 in_valid SHALL be delayed DIM-1 strobes alongside lane 0; its tap is the row-complete flag.
REQ-019 On a strobe edge with row-complete=1, the aligned row (taps of lanes 0..DIM-2 plus current lane_in lane DIM-1) SHALL be pushed to the output buffer.
REQ-020 Latency: out_valid SHALL rise on the edge after the strobe-k+DIM-1 push, given an empty buffer.
REQ-021 Output handshake: a pop occurs on any edge with out_valid=1 and out_ready=1; out_data holds the next entry afterwards.
REQ-022 out_data is don't-care while out_valid=0.
REQ-023 Push SHALL be accepted when count < OUT_DEPTH, or when count = OUT_DEPTH and a pop occurs on the same edge.
REQ-024 Rejected push: row discarded, overflow set to 1, buffer contents and order unchanged.
REQ-025 Simultaneous push and pop SHALL leave count unchanged, with FIFO order preserved.
REQ-026 Rows SHALL emerge strictly in in_valid order; no row duplicated.
REQ-027 en=0 SHALL freeze lane and valid pipelines; the output side keeps draining.
REQ-028 rows_out increments by 1 per pop and wraps 2^32-1 -> 0.
REQ-029 clr=1 SHALL zero lane pipelines, the valid pipeline, buffer count, overflow and rows_out; it overrides en, push and pop that cycle.

Reset
REQ-030 rst_n=0 SHALL have the same effect as clr=1: all pipeline registers 0, out_valid=0, almost_full=0, overflow=0, rows_out=0.
REQ-031 Reset mid-operation SHALL discard all in-flight and buffered rows; no output beat on the first edge after release.

Structure
REQ-032 Package deskew_pkg holds the default DIM/BITS/OUT_DEPTH constants, the lane element typedef, and the buffer-count width.
REQ-033 Sub-module row_fifo: synchronous OUT_DEPTH x DIM*BITS buffer with push/pop/count; instantiated once.
REQ-034 Lane delay lines are generated per lane inside deskew_unloader; no per-lane sub-module.

Verification (bench DIM=4, BITS=16, OUT_DEPTH=4)
REQ-035 Hold rst_n=0 for 2 cycles, then release -> out_valid=0, almost_full=0, overflow=0, rows_out=0.
REQ-036 en=1 always, out_ready=1, in_valid=1 on strobe 0 only, lane i = 16'h0A00+i on strobe i (0 otherwise) -> exactly one out_valid beat, 4 cycles after strobe 0, with out_data = {0A03,0A02,0A01,0A00}; rows_out=1.
REQ-037 Ten back-to-back rows (row r lane i = 16'h0100*r+i), out_ready=1 -> ten consecutive beats in order, no gaps; rows_out=10.
REQ-038 out_ready=0 with five rows pushed -> almost_full=1 after the third, fourth push accepted, fifth sets overflow=1; then out_ready=1 -> rows 0-3 drained in order; overflow stays 1.
REQ-039 REQ-037 stimulus with en toggling 1/0 each cycle -> identical output row sequence and values, at half rate.
REQ-040 clr pulse with two rows in flight and one buffered -> out_valid=0 next cycle; no beats until a new in_valid row completes; rows_out=0, overflow=0.

Source files
------------

// File: rtl/deskew_pkg.sv
// Shared constants and types for the deskew unloader: default geometry,
// lane element type and output buffer occupancy width.
package deskew_pkg;

  localparam int DIM_DEF       = 8;
  localparam int BITS_DEF      = 64;
  localparam int OUT_DEPTH_DEF = 4;

  typedef logic [BITS_DEF-1:0] lane_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(OUT_DEPTH_DEF);

endpackage

// File: rtl/deskew_unloader_if.sv
// Stream bundle around the deskew unloader: skewed lane input with strobe,
// aligned row output with valid/ready handshake.
interface deskew_unloader_if
  import deskew_pkg::*;
#(
  parameter int DIM  = DIM_DEF,
  parameter int BITS = BITS_DEF
) ();

  logic                en;
  logic                in_valid;
  logic [DIM*BITS-1:0] lane_in;
  logic [DIM*BITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output en, in_valid, lane_in, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  en, in_valid, lane_in, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/deskew_unloader_row_fifo.sv
// Synchronous row buffer: DEPTH entries of WIDTH bits, caller guarantees
// push only when space exists (or with a same-edge pop) and pop only when valid.
module row_fifo
  import deskew_pkg::*;
#(
  parameter int WIDTH = DIM_DEF * BITS_DEF,
  parameter int DEPTH = OUT_DEPTH_DEF,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             valid_o,
  output logic             almost_full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, afull_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (!rst_n_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != CW'(0));
      afull_q  <= (count_d >= CW'(DEPTH - 1));
    end
  end

  // Row storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o       = mem_q[rd_ptr_q];
  assign count_o       = count_q;
  assign valid_o       = valid_q;
  assign almost_full_o = afull_q;

endmodule

// File: rtl/deskew_unloader.sv
// Realigns DIM diagonally skewed lanes into whole rows and queues them in a
// small output buffer drained through a valid/ready handshake.
module deskew_unloader
  import deskew_pkg::*;
#(
  parameter int DIM       = DIM_DEF,
  parameter int BITS      = BITS_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  deskew_unloader_if.slave   bus,
  output logic               almost_full,
  output logic               overflow,
  output logic [31:0]        rows_out
);

  localparam int W  = DIM * BITS;
  localparam int CW = cnt_width(OUT_DEPTH);

  logic           clear_s;
  logic [DIM-2:0] vpipe_q, vpipe_d;
  logic [DIM-1:0] vshift_s;
  logic [W-1:0]   row_s;
  logic           push_req_s, push_s, pop_s;
  logic [CW-1:0]  count_s;
  logic           fifo_valid_s, fifo_afull_s;
  logic           overflow_q, overflow_d;
  logic [31:0]    rows_q, rows_d;

  assign clear_s = !rst_n || clr;

  // Lane i waits DIM-1-i strobes so every lane lines up with the last one.
  for (genvar i = 0; i < DIM - 1; i++) begin : g_lane
    localparam int DLY = DIM - 1 - i;
    logic [BITS-1:0] dl_q [DLY];

    // Per-lane delay line, advanced only on strobes.
    always_ff @(posedge clk) begin
      if (clear_s) begin
        for (int j = 0; j < DLY; j++) begin
          dl_q[j] <= '0;
        end
      end else if (bus.en) begin
        dl_q[0] <= bus.lane_in[i*BITS +: BITS];
        for (int j = 1; j < DLY; j++) begin
          dl_q[j] <= dl_q[j-1];
        end
      end
    end

    assign row_s[i*BITS +: BITS] = dl_q[DLY-1];
  end

  assign row_s[(DIM-1)*BITS +: BITS] = bus.lane_in[(DIM-1)*BITS +: BITS];

  assign vshift_s = {vpipe_q, bus.in_valid};

  // Push/pop decisions, overflow and handshake counting.
  always_comb begin
    vpipe_d    = vshift_s[DIM-2:0];
    push_req_s = bus.en && vpipe_q[DIM-2] && !clear_s;
    pop_s      = fifo_valid_s && bus.out_ready && !clear_s;
    push_s     = push_req_s && ((count_s < CW'(OUT_DEPTH)) || pop_s);
    overflow_d = overflow_q || (push_req_s && !push_s);
    if (pop_s) begin
      rows_d = rows_q + 32'd1;
    end else begin
      rows_d = rows_q;
    end
  end

  // Row-start pipeline and status registers.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      vpipe_q    <= '0;
      overflow_q <= 1'b0;
      rows_q     <= 32'd0;
    end else begin
      if (bus.en) begin
        vpipe_q <= vpipe_d;
      end
      overflow_q <= overflow_d;
      rows_q     <= rows_d;
    end
  end

  row_fifo #(
    .WIDTH (W),
    .DEPTH (OUT_DEPTH)
  ) u_row_fifo (
    .clk           (clk),
    .rst_n_i       (rst_n),
    .clr_i         (clr),
    .push_i        (push_s),
    .pop_i         (pop_s),
    .wdata_i       (row_s),
    .rdata_o       (bus.out_data),
    .count_o       (count_s),
    .valid_o       (fifo_valid_s),
    .almost_full_o (fifo_afull_s)
  );

  assign bus.out_valid = fifo_valid_s;
  assign almost_full   = fifo_afull_s;
  assign overflow      = overflow_q;
  assign rows_out      = rows_q;

endmodule
